// File: rtl/ram_dma_engine.sv
// ram_dma_engine
//   Block-transfer master for one port of a dual-port RAM. Runs either a FILL
//   (constant written over an address range) or a COPY (range to range,
//   strictly ascending, one word at a time). The other RAM port stays free.
//
//   Optional feature macro: RAM_DMA_ABORT_EN. When defined, an `abort` input
//   is added that terminates a running transfer at the next posedge.
//
// Parameters
//   ADRW  RAM address width (depth 2**ADRW words)
//   DATW  RAM data width
//
// Ports
//   clock        system clock, posedge
//   reset_n      asynchronous active-low reset
//   start        one-cycle request, sampled only while idle
//   mode         0 = FILL, 1 = COPY (sampled with start)
//   src_addr     COPY source start address (sampled with start)
//   dst_addr     destination start address (sampled with start)
//   length       word count 0..2**ADRW (sampled with start)
//   fill_data    FILL value (sampled with start)
//   abort        (RAM_DMA_ABORT_EN only) terminate the running transfer
//   busy         high while a transfer is in progress
//   done         one-cycle completion pulse
//   ram_address  registered RAM address
//   ram_wren     registered RAM write enable
//   ram_data     RAM write data: ram_q while writing a COPY word, else fill value
//   ram_q        RAM read data, valid the cycle after the read address
module ram_dma_engine #(
  parameter int ADRW = 8,
  parameter int DATW = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            mode,
  input  logic [ADRW-1:0] src_addr,
  input  logic [ADRW-1:0] dst_addr,
  input  logic [ADRW:0]   length,
  input  logic [DATW-1:0] fill_data,
`ifdef RAM_DMA_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [ADRW-1:0] ram_address,
  output logic            ram_wren,
  output logic [DATW-1:0] ram_data,
  input  logic [DATW-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RD,
    WR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ADRW-1:0] src_ptr;
  logic [ADRW-1:0] src_nxt;
  logic [ADRW-1:0] dst_ptr;
  logic [ADRW-1:0] dst_nxt;
  logic [ADRW-1:0] addr_nxt;
  logic [ADRW:0]   remain;
  logic [ADRW:0]   remain_nxt;
  logic [DATW-1:0] fill_val;
  logic [DATW-1:0] fill_nxt;
  logic            wren_nxt;
  logic            done_nxt;
  logic            abort_req;

`ifdef RAM_DMA_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // src_ptr/dst_ptr always hold the address of the NEXT access of their kind;
  // remain counts the words still to be started after the current one, so
  // the last word is recognised by remain == 0 without a separate compare.
  always_comb begin
    state_nxt  = state;
    src_nxt    = src_ptr;
    dst_nxt    = dst_ptr;
    remain_nxt = remain;
    fill_nxt   = fill_val;
    addr_nxt   = ram_address;
    wren_nxt   = 1'b0;
    done_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          fill_nxt = fill_data;
          if (length == '0) begin
            done_nxt = 1'b1;
          end else begin
            remain_nxt = length - (ADRW+1)'(1);
            if (mode) begin
              state_nxt = RD;
              addr_nxt  = src_addr;
              src_nxt   = src_addr + ADRW'(1);
              dst_nxt   = dst_addr;
            end else begin
              state_nxt = FILL;
              addr_nxt  = dst_addr;
              wren_nxt  = 1'b1;
              src_nxt   = src_addr;
              dst_nxt   = dst_addr + ADRW'(1);
            end
          end
        end
      end

      FILL: begin
        if (abort_req || remain == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt   = dst_ptr;
          wren_nxt   = 1'b1;
          dst_nxt    = dst_ptr + ADRW'(1);
          remain_nxt = remain - (ADRW+1)'(1);
        end
      end

      RD: begin
        if (abort_req) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = WR;
          addr_nxt  = dst_ptr;
          wren_nxt  = 1'b1;
          dst_nxt   = dst_ptr + ADRW'(1);
        end
      end

      WR: begin
        if (abort_req || remain == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt  = RD;
          addr_nxt   = src_ptr;
          src_nxt    = src_ptr + ADRW'(1);
          remain_nxt = remain - (ADRW+1)'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remain      <= '0;
      fill_val    <= '0;
      ram_address <= '0;
      ram_wren    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      src_ptr     <= src_nxt;
      dst_ptr     <= dst_nxt;
      remain      <= remain_nxt;
      fill_val    <= fill_nxt;
      ram_address <= addr_nxt;
      ram_wren    <= wren_nxt;
      done        <= done_nxt;
    end
  end

  assign busy     = (state != IDLE);
  // COPY writes forward the RAM read data straight through; the read was
  // issued in the preceding RD cycle.
  assign ram_data = (state == WR) ? ram_q : fill_val;

  a_wren_only_when_writing : assert property (
    @(posedge clock) disable iff (!reset_n)
    ram_wren |-> (state == FILL || state == WR));

  a_done_only_idle : assert property (
    @(posedge clock) disable iff (!reset_n)
    done |-> !busy);

endmodule
